// File: rtl/vx_hs_ram_pkg.sv
// Shared definitions for the handshaked RAM: FSM state encoding and the
// response credit depth derived from the output-register option.
package vx_hs_ram_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int calc_credits(input int out_reg);
    return 2 + out_reg;
  endfunction

endpackage

// File: rtl/vx_hs_ram_rspq.sv
// Response queue for the handshaked RAM: small FIFO whose head is bypassed
// from the input while empty, with registered empty/full flags.
module vx_hs_ram_rspq
  import vx_hs_ram_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_valid_i,
  input  logic [DATAW-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic             rsp_valid_o,
  output logic [DATAW-1:0] rsp_data_o
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [DATAW-1:0] buf_q [DEPTH];
  logic [PTRW-1:0]  rd_q, rd_d;
  logic [PTRW-1:0]  wr_q, wr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             empty_q, full_q;
  logic             push, pop;

  // An item arriving at an empty queue that is consumed immediately never gets stored.
  assign pop  = !empty_q && pop_ready_i;
  assign push = push_valid_i && !full_q && !(empty_q && pop_ready_i);

  assign rsp_valid_o = empty_q ? push_valid_i : 1'b1;
  assign rsp_data_o  = empty_q ? push_data_i : buf_q[rd_q];

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (pop) begin
      rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
    end
    if (push) begin
      wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FULL_CNT);
      if (push) begin
        buf_q[wr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/vx_hs_ram.sv
// Handshaked single-port RAM with credit-limited in-order read responses,
// optional output register stage and a post-reset clear sweep.
module vx_hs_ram
  import vx_hs_ram_pkg::*;
#(
  parameter int               DATAW      = 32,
  parameter int               SIZE       = 64,
  parameter int               BYTEENW    = 4,
  parameter int               OUT_REG    = 0,
  parameter int               HW_INIT    = 1,
  parameter logic [DATAW-1:0] INIT_VALUE = '0,
  parameter int               ADDRW      = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  input  logic               req_rw,
  input  logic [ADDRW-1:0]   req_addr,
  input  logic [BYTEENW-1:0] req_byteen,
  input  logic [DATAW-1:0]   req_data,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic [DATAW-1:0]   rsp_data,
  input  logic               rsp_ready,
  output logic               init_done
);

  localparam int CREDITS = calc_credits(OUT_REG);
  localparam int CNTW    = $clog2(CREDITS + 1);
  localparam logic [CNTW-1:0]  CREDITS_C   = CNTW'(CREDITS);
  localparam logic [ADDRW-1:0] LAST_ADDR   = ADDRW'(SIZE - 1);
  localparam logic [0:0]       RESET_STATE = (HW_INIT != 0) ? ST_INIT : ST_RUN;

  logic [DATAW-1:0] mem [SIZE];

  logic [0:0]       state_q, state_d;
  logic [ADDRW-1:0] sweep_q, sweep_d;
  logic             init_done_q;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             req_fire, rd_fire, wr_fire, rsp_fire;
  logic             s0_valid_q;
  logic [DATAW-1:0] s0_data_q;
  logic             pipe_valid;
  logic [DATAW-1:0] pipe_data;

  // init_done_q lags the RUN transition by one cycle and gates all requests.
  assign req_ready = init_done_q && (cnt_q < CREDITS_C);
  assign init_done = init_done_q;

  assign req_fire = req_valid && req_ready;
  assign rd_fire  = req_fire && !req_rw;
  assign wr_fire  = req_fire && req_rw;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == LAST_ADDR) begin
        state_d = ST_RUN;
        sweep_d = '0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rd_fire && !rsp_fire) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!rd_fire && rsp_fire) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= (state_q == ST_RUN);
      cnt_q       <= cnt_d;
    end
  end

  if (BYTEENW > 1) begin : g_lanes
    always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
        mem[sweep_q] <= INIT_VALUE;
      end else if (wr_fire) begin
        for (int i = 0; i < BYTEENW; i++) begin
          if (req_byteen[i]) begin
            mem[req_addr][i*8 +: 8] <= req_data[i*8 +: 8];
          end
        end
      end
    end
  end else begin : g_word
    always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
        mem[sweep_q] <= INIT_VALUE;
      end else if (wr_fire && req_byteen[0]) begin
        mem[req_addr] <= req_data;
      end
    end
  end

  // The pipeline never stalls: credits bound in-flight reads to the queue depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= rd_fire;
      if (rd_fire) begin
        s0_data_q <= mem[req_addr];
      end
    end
  end

  if (OUT_REG != 0) begin : g_outreg
    logic             s1_valid_q;
    logic [DATAW-1:0] s1_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s0_valid_q;
        if (s0_valid_q) begin
          s1_data_q <= s0_data_q;
        end
      end
    end

    assign pipe_valid = s1_valid_q;
    assign pipe_data  = s1_data_q;
  end else begin : g_noreg
    assign pipe_valid = s0_valid_q;
    assign pipe_data  = s0_data_q;
  end

  vx_hs_ram_rspq #(
    .DATAW (DATAW),
    .DEPTH (CREDITS)
  ) u_rspq (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_valid_i (pipe_valid),
    .push_data_i  (pipe_data),
    .pop_ready_i  (rsp_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data)
  );

endmodule
